// File: rtl/shift_pipe_if.sv
// shift_pipe handshake bundle: operand/amount/op/tag in, result/carry/tag out.
// slave = shifter side, master = producer/consumer side.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ShiftSource;
  logic [AMT_W-1:0] ShiftAmount;
  logic [2:0]       ShiftSel;
  logic             carry_in;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ShiftResult;
  logic             carry_out;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, ShiftSource, ShiftAmount,
    input  ShiftSel, carry_in, in_tag, out_ready,
    output in_ready, out_valid, ShiftResult,
    output carry_out, out_tag
  );

  modport master (
    output in_valid, ShiftSource, ShiftAmount,
    output ShiftSel, carry_in, in_tag, out_ready,
    input  in_ready, out_valid, ShiftResult,
    input  carry_out, out_tag
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX) with ARM carry-out, tag,
// valid/ready backpressure and flush. Ports: clk, reset (async low), flush, io.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  shift_pipe_if.slave io
);
  localparam int AMT_W = $clog2(WIDTH) + 1;
  localparam int LW    = $clog2(WIDTH);

  logic [WIDTH-1:0] s;
  logic [AMT_W-1:0] n;
  logic [2:0]       sel;
  logic             nz;
  logic             do_lsl, do_lsr, do_asr;
  logic             do_ror, do_rrx;

  assign s   = io.ShiftSource;
  assign n   = io.ShiftAmount;
  assign sel = io.ShiftSel;
  assign nz  = |n;

  // n = 0 falls to the default passthrough; RRX ignores n
  assign do_lsl = nz & (sel == 3'd0);
  assign do_lsr = nz & (sel == 3'd1);
  assign do_asr = nz & (sel == 3'd2);
  assign do_ror = nz & (sel == 3'd3);
  assign do_rrx = (sel == 3'd4);

  // One extra bit catches the carry; oversize
  // amounts shift it out to 0 (or sign for ASR)
  logic [WIDTH:0]        lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_in, asr_w;
  logic [LW-1:0]         rot;
  logic [AMT_W-1:0]      rot_l;
  logic [WIDTH-1:0]      ror_w;

  assign lsl_w  = {1'b0, s} << n;
  assign lsr_w  = {s, 1'b0} >> n;
  assign asr_in = {s, 1'b0};
  assign asr_w  = asr_in >>> n;
  assign rot    = n[LW-1:0];
  assign rot_l  = AMT_W'(WIDTH) - {1'b0, rot};
  assign ror_w  = (s >> rot) | (s << rot_l);

  logic [WIDTH-1:0] res_c;
  logic             co_c;

  always_comb begin
    res_c = s;
    co_c  = io.carry_in;
    unique case (1'b1)
      do_lsl: {co_c, res_c} = lsl_w;
      do_lsr: {res_c, co_c} = lsr_w;
      do_asr: {res_c, co_c} = asr_w;
      do_ror: begin
        res_c = ror_w;
        co_c  = ror_w[WIDTH-1];
      end
      do_rrx: begin
        res_c = {io.carry_in, s[WIDTH-1:1]};
        co_c  = s[0];
      end
      default: ;
    endcase
  end

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [STAGES-1:0]            co_q, co_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                         stall, accept;

  assign stall       = vld_q[STAGES-1] & ~io.out_ready;
  assign accept      = io.in_valid & ~stall;
  assign io.in_ready = ~stall;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    co_d  = co_q;
    tag_d = tag_q;
    if (!stall) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        co_d[i]  = co_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      vld_d[0] = accept;
      if (accept) begin
        res_d[0] = res_c;
        co_d[0]  = co_c;
        tag_d[0] = io.in_tag;
      end
    end
    // flush wins over stall and drops the op presented now
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      res_q <= '0;
      co_q  <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      co_q  <= co_d;
      tag_q <= tag_d;
    end
  end

  assign io.out_valid   = vld_q[STAGES-1];
  assign io.ShiftResult = res_q[STAGES-1];
  assign io.carry_out   = co_q[STAGES-1];
  assign io.out_tag     = tag_q[STAGES-1];
endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe (WIDTH=32, STAGES=2, TAG_W=4).
// Immediate assertions compare each output against hand-computed values.
module tb_shift_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  shift_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             name, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel,
                       input logic [31:0] src,
                       input logic [5:0] amt,
                       input logic cin,
                       input logic [3:0] tag);
    bus.ShiftSel    = sel;
    bus.ShiftSource = src;
    bus.ShiftAmount = amt;
    bus.carry_in    = cin;
    bus.in_tag      = tag;
  endtask

  // accept at edge N, result visible after edge N+1
  task automatic run_op(input string name,
                        input logic [2:0] sel,
                        input logic [31:0] src,
                        input logic [5:0] amt,
                        input logic cin,
                        input logic [3:0] tag,
                        input logic [31:0] er,
                        input logic ec);
    drive(sel, src, amt, cin, tag);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({name, "_early_valid"}, 64'(bus.out_valid), 64'd0);
    tick();
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_res"}, 64'(bus.ShiftResult), 64'(er));
    check({name, "_carry"}, 64'(bus.carry_out), 64'(ec));
    check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
  endtask

  initial begin
    logic [31:0] held;
    int sent;
    int exp_t;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(3'd0, 32'h0, 6'd0, 1'b0, 4'd0);
    #1 reset = 1'b0;
    #3;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_res", 64'(bus.ShiftResult), 64'd0);
    check("rst_carry", 64'(bus.carry_out), 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk) reset = 1'b1;
    tick();

    run_op("lsl1", 3'd0, 32'h8000_0001, 6'd1, 1'b0, 4'd1,
           32'h0000_0002, 1'b1);
    run_op("asr40", 3'd2, 32'h8000_0000, 6'd40, 1'b0, 4'd2,
           32'hFFFF_FFFF, 1'b1);
    run_op("lsr32", 3'd1, 32'h8000_0000, 6'd32, 1'b0, 4'd3,
           32'h0000_0000, 1'b1);
    run_op("ror33", 3'd3, 32'h0000_0001, 6'd33, 1'b0, 4'd4,
           32'h8000_0000, 1'b1);
    run_op("ror32", 3'd3, 32'h1234_5678, 6'd32, 1'b1, 4'd5,
           32'h1234_5678, 1'b0);
    run_op("ror0", 3'd3, 32'h1234_5678, 6'd0, 1'b1, 4'd6,
           32'h1234_5678, 1'b1);
    run_op("rrx", 3'd4, 32'h0000_0003, 6'd5, 1'b1, 4'd7,
           32'h8000_0001, 1'b1);
    run_op("rsv7", 3'd7, 32'hDEAD_BEEF, 6'd3, 1'b0, 4'd8,
           32'hDEAD_BEEF, 1'b0);
    run_op("lsl32", 3'd0, 32'h0000_0001, 6'd32, 1'b0, 4'd9,
           32'h0000_0000, 1'b1);
    run_op("lsl33", 3'd0, 32'hFFFF_FFFF, 6'd33, 1'b1, 4'd10,
           32'h0000_0000, 1'b0);
    run_op("lsr4", 3'd1, 32'h0000_00F0, 6'd4, 1'b1, 4'd11,
           32'h0000_000F, 1'b0);
    run_op("asr4", 3'd2, 32'h8000_00F8, 6'd4, 1'b0, 4'd12,
           32'hF800_000F, 1'b1);
    run_op("lsl0", 3'd0, 32'hCAFE_0001, 6'd0, 1'b1, 4'd13,
           32'hCAFE_0001, 1'b1);
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // stream tags 1..6, consumer stalls in cycles 4..6
    sent  = 1;
    exp_t = 1;
    held  = '0;
    for (int c = 0; c < 40 && exp_t <= 6; c++) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      bus.in_valid  = (sent <= 6);
      drive(3'd0, 32'(sent) << 4, 6'd4, 1'b0, 4'(sent));
      #1;
      if (!bus.out_ready) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_tag", 64'(bus.out_tag), 64'(exp_t));
        if (c == 4) held = bus.ShiftResult;
        else check("stall_hold", 64'(bus.ShiftResult), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream_tag", 64'(bus.out_tag), 64'(exp_t));
        check("stream_res", 64'(bus.ShiftResult),
              64'(32'(exp_t) << 8));
        exp_t++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 64'(exp_t), 64'd7);
    check("stream_sent", 64'(sent), 64'd7);
    tick();
    check("stream_drain", 64'(bus.out_valid), 64'd0);

    // async reset with two ops in flight
    drive(3'd0, 32'hAAAA_5555, 6'd0, 1'b1, 4'd5);
    bus.in_valid = 1'b1;
    tick();
    drive(3'd0, 32'h5555_AAAA, 6'd0, 1'b1, 4'd6);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_res", 64'(bus.ShiftResult), 64'd0);
    check("arst_carry", 64'(bus.carry_out), 64'd0);
    check("arst_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    run_op("after_rst", 3'd1, 32'h0000_0100, 6'd8, 1'b0, 4'd14,
           32'h0000_0001, 1'b0);
    tick();

    // flush with two ops in flight while the consumer stalls
    bus.out_ready = 1'b0;
    drive(3'd0, 32'h0000_0011, 6'd1, 1'b0, 4'd10);
    bus.in_valid = 1'b1;
    tick();
    drive(3'd0, 32'h0000_0022, 6'd1, 1'b0, 4'd11);
    tick();
    check("pre_flush_valid", 64'(bus.out_valid), 64'd1);
    check("pre_flush_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(3'd0, 32'h0000_0033, 6'd1, 1'b0, 4'd12);
    tick();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("flush_valid0", 64'(bus.out_valid), 64'd0);
    tick();
    check("flush_valid1", 64'(bus.out_valid), 64'd0);
    tick();
    check("flush_valid2", 64'(bus.out_valid), 64'd0);
    run_op("after_flush", 3'd3, 32'h0000_00F0, 6'd4, 1'b0, 4'd13,
           32'h0000_000F, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
